// File: rtl/alu_mdu_seq.sv
// Execute unit: single-cycle ALU ops plus iterative RV32M multiply/divide behind valid/ready.
// Optional macro ALU_MDU_FAST_ZERO_EN: zero-operand mul and divide-by-zero finish in one clock.
module alu_mdu_seq #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         valid_alu_i,
    output logic         ready_alu_o,
    input  logic [W-1:0] opr_a_alu_i,
    input  logic [W-1:0] opr_b_alu_i,
    input  logic [5:0]   op_alu_i,
    output logic         valid_alu_o,
    input  logic         ready_alu_i,
    output logic [W-1:0] res_alu_o,
    output logic         z_alu_o,
    output logic         n_alu_o,
    output logic         busy_alu_o
);
    localparam int CNT_W = $clog2(W) + 1;
    localparam int SH_W  = $clog2(W);

    localparam logic [5:0] ADD_OP  = 6'd0,  SUB_OP    = 6'd1,  SHL_OP   = 6'd2,  LSR_OP  = 6'd3;
    localparam logic [5:0] ASR_OP  = 6'd4,  OR_OP     = 6'd5,  AND_OP   = 6'd6,  NOR_OP  = 6'd7;
    localparam logic [5:0] XOR_OP  = 6'd8,  SLT_OP    = 6'd9,  SLTU_OP  = 6'd10;
    localparam logic [5:0] MUL_OP  = 6'd16, MULH_OP   = 6'd17, MULHSU_OP = 6'd18, MULHU_OP = 6'd19;
    localparam logic [5:0] DIV_OP  = 6'd20, DIVU_OP   = 6'd21, REM_OP   = 6'd22, REMU_OP = 6'd23;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [W-1:0]         a_q, b_q, hi, lo, hi_nxt, lo_nxt;
    logic [5:0]           op_q;
    logic                 sa, sb, sa_in, fz;
    logic [W-1:0]         b_mag, a_mag_in;
    logic [W:0]           mul_sum, div_sh, div_diff;

    function automatic logic is_mul(input logic [5:0] op);
        return op inside {MUL_OP, MULH_OP, MULHSU_OP, MULHU_OP};
    endfunction

    function automatic logic is_div(input logic [5:0] op);
        return op inside {DIV_OP, DIVU_OP, REM_OP, REMU_OP};
    endfunction

    function automatic logic a_signed(input logic [5:0] op);
        return op inside {MUL_OP, MULH_OP, MULHSU_OP, DIV_OP, REM_OP};
    endfunction

    function automatic logic b_signed(input logic [5:0] op);
        return op inside {MUL_OP, MULH_OP, DIV_OP, REM_OP};
    endfunction

    // {z, n}: n is the overflow-corrected sign of A - B, i.e. signed A < B
    function automatic logic [1:0] flags(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] d;
        logic         ovf;
        d   = a + ~b + 1'b1;
        ovf = (a[W-1] ^ b[W-1]) & (d[W-1] ^ a[W-1]);
        return {d == '0, d[W-1] ^ ovf};
    endfunction

    function automatic logic [W-1:0] alu_single(input logic [5:0] op, input logic [W-1:0] a,
                                                 input logic [W-1:0] b);
        logic signed [W-1:0] as;
        logic [SH_W-1:0]     sh;
        logic [1:0]          f;
        as = a;
        sh = b[SH_W-1:0];
        f  = flags(a, b);
        case (op)
            ADD_OP:  return a + b;
            SUB_OP:  return a + ~b + 1'b1;
            SHL_OP:  return a << sh;
            LSR_OP:  return a >> sh;
            ASR_OP:  return as >>> sh;
            OR_OP:   return a | b;
            AND_OP:  return a & b;
            NOR_OP:  return ~(a | b);
            XOR_OP:  return a ^ b;
            SLT_OP:  return {{(W-1){1'b0}}, f[0]};
            SLTU_OP: return {{(W-1){1'b0}}, a < b};
            default: return '0;
        endcase
    endfunction

    // Sign fix-up of the magnitude result; divide-by-zero values are forced here
    function automatic logic [W-1:0] fin_result(input logic [5:0] op, input logic [W-1:0] hi_v,
                                                 input logic [W-1:0] lo_v, input logic [W-1:0] a_v,
                                                 input logic neg, input logic neg_r,
                                                 input logic b_zero);
        logic [2*W-1:0] prod;
        prod = {hi_v, lo_v};
        if (neg) prod = -prod;
        case (op)
            MUL_OP:                      return prod[W-1:0];
            MULH_OP, MULHSU_OP, MULHU_OP: return prod[2*W-1:W];
            DIV_OP, DIVU_OP:             return b_zero ? '1 : (neg ? -lo_v : lo_v);
            REM_OP, REMU_OP:             return b_zero ? a_v : (neg_r ? -hi_v : hi_v);
            default:                     return '0;
        endcase
    endfunction

    assign sa       = a_signed(op_q) & a_q[W-1];
    assign sb       = b_signed(op_q) & b_q[W-1];
    assign b_mag    = sb ? -b_q : b_q;
    assign sa_in    = a_signed(op_alu_i) & opr_a_alu_i[W-1];
    assign a_mag_in = sa_in ? -opr_a_alu_i : opr_a_alu_i;

    assign mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, b_mag} : '0);
    assign div_sh   = {hi, lo[W-1]};
    assign div_diff = div_sh - {1'b0, b_mag};

`ifdef ALU_MDU_FAST_ZERO_EN
    assign fz = (is_mul(op_alu_i) && (opr_a_alu_i == '0 || opr_b_alu_i == '0)) ||
                (is_div(op_alu_i) && opr_b_alu_i == '0);
`else
    assign fz = 1'b0;
`endif

    always_comb begin
        hi_nxt = hi;
        lo_nxt = lo;
        if (state == MUL) begin
            hi_nxt = mul_sum[W:1];
            lo_nxt = {mul_sum[0], lo[W-1:1]};
        end else if (state == DIV) begin
            hi_nxt = div_diff[W] ? div_sh[W-1:0] : div_diff[W-1:0];
            lo_nxt = {lo[W-2:0], ~div_diff[W]};
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (valid_alu_i) begin
                if (fz)                       state_nxt = DONE;
                else if (is_mul(op_alu_i))    state_nxt = MUL;
                else if (is_div(op_alu_i))    state_nxt = DIV;
                else                          state_nxt = DONE;
            end
            MUL, DIV: if (cnt == CNT_W'(1)) state_nxt = DONE;
            DONE:     if (ready_alu_i)      state_nxt = IDLE;
            default:                        state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Control and result registers: cleared by reset so no stale result survives
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt       <= '0;
            res_alu_o <= '0;
            z_alu_o   <= 1'b0;
            n_alu_o   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (valid_alu_i) begin
                    cnt                <= CNT_W'(W);
                    {z_alu_o, n_alu_o} <= flags(opr_a_alu_i, opr_b_alu_i);
                    if (fz)
                        res_alu_o <= is_mul(op_alu_i) ? '0 :
                                     (op_alu_i inside {DIV_OP, DIVU_OP}) ? '1 : opr_a_alu_i;
                    else if (!is_mul(op_alu_i) && !is_div(op_alu_i))
                        res_alu_o <= alu_single(op_alu_i, opr_a_alu_i, opr_b_alu_i);
                end
                MUL, DIV: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1))
                        res_alu_o <= fin_result(op_q, hi_nxt, lo_nxt, a_q, sa ^ sb, sa, b_q == '0);
                end
                default: ;
            endcase
        end
    end

    // Operand and iteration datapath: loaded on accept, no reset needed
    always_ff @(posedge clk) begin
        if (state == IDLE) begin
            if (valid_alu_i) begin
                a_q  <= opr_a_alu_i;
                b_q  <= opr_b_alu_i;
                op_q <= op_alu_i;
                hi   <= '0;
                lo   <= a_mag_in;
            end
        end else begin
            hi <= hi_nxt;
            lo <= lo_nxt;
        end
    end

    assign ready_alu_o = (state == IDLE);
    assign valid_alu_o = (state == DONE);
    assign busy_alu_o  = (state == MUL) || (state == DIV);
endmodule

// File: tb/tb_alu_mdu_seq.sv
// Directed self-checking bench for alu_mdu_seq (W=32); honours ALU_MDU_FAST_ZERO_EN for /0 latency.
module tb_alu_mdu_seq;
    localparam int W = 32;
    localparam logic [5:0] ADD_OP  = 6'd0,  SUB_OP    = 6'd1,  SHL_OP   = 6'd2,  LSR_OP  = 6'd3;
    localparam logic [5:0] ASR_OP  = 6'd4,  OR_OP     = 6'd5,  AND_OP   = 6'd6,  NOR_OP  = 6'd7;
    localparam logic [5:0] XOR_OP  = 6'd8,  SLT_OP    = 6'd9,  SLTU_OP  = 6'd10;
    localparam logic [5:0] MUL_OP  = 6'd16, MULH_OP   = 6'd17, MULHSU_OP = 6'd18, MULHU_OP = 6'd19;
    localparam logic [5:0] DIV_OP  = 6'd20, DIVU_OP   = 6'd21, REM_OP   = 6'd22, REMU_OP = 6'd23;
`ifdef ALU_MDU_FAST_ZERO_EN
    localparam int DZ_LAT = 1;
`else
    localparam int DZ_LAT = 33;
`endif

    logic         clk = 1'b0;
    logic         reset_n, valid_alu_i, ready_alu_o, valid_alu_o, ready_alu_i;
    logic [W-1:0] opr_a_alu_i, opr_b_alu_i, res_alu_o;
    logic [5:0]   op_alu_i;
    logic         z_alu_o, n_alu_o, busy_alu_o;
    int           checks = 0;
    int           failures = 0;

    always #5 clk = ~clk;

    alu_mdu_seq #(.W(W)) dut (
        .clk(clk), .reset_n(reset_n), .valid_alu_i(valid_alu_i), .ready_alu_o(ready_alu_o),
        .opr_a_alu_i(opr_a_alu_i), .opr_b_alu_i(opr_b_alu_i), .op_alu_i(op_alu_i),
        .valid_alu_o(valid_alu_o), .ready_alu_i(ready_alu_i), .res_alu_o(res_alu_o),
        .z_alu_o(z_alu_o), .n_alu_o(n_alu_o), .busy_alu_o(busy_alu_o)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        op_alu_i    = op;
        opr_a_alu_i = a;
        opr_b_alu_i = b;
        valid_alu_i = 1'b1;
        tick();
        valid_alu_i = 1'b0;
        op_alu_i    = ADD_OP;
        opr_a_alu_i = 32'hDEAD_BEEF;
        opr_b_alu_i = 32'h1234_5678;
    endtask

    // Issue, wait for result (bounded), check latency/result/ready; leaves unit in DONE
    task automatic run(input string tag, input logic [5:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] exp_res, input int exp_lat);
        int   lat;
        logic rdy_seen;
        issue(op, a, b);
        lat      = 1;
        rdy_seen = 1'b0;
        while (!valid_alu_o && lat < 100) begin
            if (ready_alu_o) rdy_seen = 1'b1;
            tick();
            lat++;
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_res"}, res_alu_o, exp_res);
        chk({tag, "_rdy_low"}, {31'b0, rdy_seen | ready_alu_o}, 32'd0);
    endtask

    task automatic ack();
        ready_alu_i = 1'b1;
        tick();
    endtask

    initial begin
        logic stale;
        reset_n = 1'b0; valid_alu_i = 1'b0; ready_alu_i = 1'b1;
        op_alu_i = ADD_OP; opr_a_alu_i = '0; opr_b_alu_i = '0;
        tick(); tick();
        chk("rst_ready", {31'b0, ready_alu_o}, 32'd1);
        chk("rst_valid", {31'b0, valid_alu_o}, 32'd0);
        chk("rst_res", res_alu_o, 32'd0);
        chk("rst_zn", {30'b0, z_alu_o, n_alu_o}, 32'd0);
        chk("rst_busy", {31'b0, busy_alu_o}, 32'd0);
        reset_n = 1'b1;
        tick();

        run("add_ovf", ADD_OP, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1);
        ack();
        chk("add_ready_after", {31'b0, ready_alu_o}, 32'd1);
        chk("add_valid_after", {31'b0, valid_alu_o}, 32'd0);

        run("slt", SLT_OP, 32'h8000_0000, 32'd1, 32'd1, 1);
        chk("slt_n", {31'b0, n_alu_o}, 32'd1);
        ack();
        run("sltu", SLTU_OP, 32'h8000_0000, 32'd1, 32'd0, 1); ack();
        run("sub_eq", SUB_OP, 32'd5, 32'd5, 32'd0, 1);
        chk("sub_z", {31'b0, z_alu_o}, 32'd1);
        chk("sub_n", {31'b0, n_alu_o}, 32'd0);
        ack();
        run("sub_wrap", SUB_OP, 32'd3, 32'd5, 32'hFFFF_FFFE, 1); ack();
        run("shl", SHL_OP, 32'd1, 32'd35, 32'd8, 1); ack();
        run("lsr", LSR_OP, 32'h8000_0000, 32'd4, 32'h0800_0000, 1); ack();
        run("asr", ASR_OP, 32'h8000_0000, 32'd4, 32'hF800_0000, 1); ack();
        run("nor", NOR_OP, 32'h0F0F_0000, 32'h0000_00F0, 32'hF0F0_FF0F, 1); ack();
        run("xor", XOR_OP, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'hF0F0_F0F0, 1); ack();
        run("and", AND_OP, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1); ack();
        run("or", OR_OP, 32'hFF00_0000, 32'h0000_00FF, 32'hFF00_00FF, 1); ack();

        run("mulh_ss", MULH_OP, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33); ack();
        run("mulhu", MULHU_OP, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33); ack();
        run("mul_neg", MUL_OP, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33); ack();
        run("mulhsu", MULHSU_OP, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33); ack();
        run("div_ovf", DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33); ack();
        run("rem_ovf", REM_OP, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33); ack();
        run("div_neg", DIV_OP, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33); ack();
        run("rem_neg", REM_OP, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33); ack();
        run("divu_big", DIVU_OP, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 33); ack();
        run("divu_z", DIVU_OP, 32'd7, 32'd0, 32'hFFFF_FFFF, DZ_LAT); ack();
        run("remu_z", REMU_OP, 32'd7, 32'd0, 32'd7, DZ_LAT); ack();
        run("div_z_neg", DIV_OP, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, DZ_LAT); ack();
        run("rem_z_neg", REM_OP, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, DZ_LAT); ack();

        // Back-pressure: result held, new requests ignored
        ready_alu_i = 1'b0;
        run("mul_hold", MUL_OP, 32'd6, 32'd7, 32'd42, 33);
        for (int i = 0; i < 5; i++) begin
            op_alu_i = SUB_OP; opr_a_alu_i = 32'd1; opr_b_alu_i = 32'd9; valid_alu_i = 1'b1;
            tick();
            chk("hold_valid", {31'b0, valid_alu_o}, 32'd1);
            chk("hold_res", res_alu_o, 32'd42);
            chk("hold_ready", {31'b0, ready_alu_o}, 32'd0);
        end
        valid_alu_i = 1'b0;
        ack();
        chk("hold_rel_ready", {31'b0, ready_alu_o}, 32'd1);
        chk("hold_rel_valid", {31'b0, valid_alu_o}, 32'd0);
        tick();
        chk("hold_no_accept", {31'b0, valid_alu_o}, 32'd0);

        // Reset during the 10th divide iteration
        issue(DIV_OP, 32'd100, 32'd3);
        for (int i = 0; i < 9; i++) tick();
        chk("div_busy", {31'b0, busy_alu_o}, 32'd1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("mid_rst_ready", {31'b0, ready_alu_o}, 32'd1);
        chk("mid_rst_valid", {31'b0, valid_alu_o}, 32'd0);
        chk("mid_rst_res", res_alu_o, 32'd0);
        chk("mid_rst_busy", {31'b0, busy_alu_o}, 32'd0);
        stale = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (valid_alu_o) stale = 1'b1;
        end
        chk("no_stale", {31'b0, stale}, 32'd0);
        run("add_after", ADD_OP, 32'd2, 32'd3, 32'd5, 1); ack();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
